// File: rtl/ibex_bus_arbiter_if.sv
// Bus bundle between the Ibex instruction/data ports, the arbiter and the Avalon-MM host port.
// The master modport is the arbiter's view; slave is the environment's view.
interface ibex_bus_arbiter_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;

   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   logic [31:0] avm_address_o;
   logic        avm_read_o;
   logic        avm_write_o;
   logic [3:0]  avm_byteenable_o;
   logic [31:0] avm_writedata_o;
   logic        avm_waitrequest_i;
   logic        avm_readdatavalid_i;
   logic        avm_writeresponsevalid_i;
   logic [31:0] avm_readdata_i;
   logic [1:0]  avm_response_i;

   modport master (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  avm_waitrequest_i, avm_readdatavalid_i, avm_writeresponsevalid_i,
      input  avm_readdata_i, avm_response_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o
   );

   modport slave (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output avm_waitrequest_i, avm_readdatavalid_i, avm_writeresponsevalid_i,
      output avm_readdata_i, avm_response_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o
   );
endinterface

// File: rtl/ibex_bus_arbiter.sv
// Two-way arbiter merging the Ibex instruction and data ports onto one Avalon-MM host port.
// Commands are accepted with zero added latency; an in-order tag FIFO routes responses back.
module ibex_bus_arbiter #(
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ibex_bus_arbiter_if.master bus,
   output logic               protocol_err_o
);

   localparam logic [2:0] MaxCnt  = 3'(MAX_OUTST);
   localparam logic [1:0] LastPtr = 2'(MAX_OUTST - 1);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e      state_q;
   logic        locked_src_q;  // 0 = instr, 1 = data
   logic        rr_q;          // source that wins when both request
   logic [2:0]  count_q;
   logic [1:0]  wr_ptr_q;
   logic [1:0]  rd_ptr_q;
   logic [3:0]  tag_q;
   logic        proto_err_q;

   logic win_src, win_valid, rsp, rsp_ok, room, cmd, accept, head_src, win_we;

   // Winner selection: frozen while locked, otherwise single request or round-robin.
   always_comb begin
      win_src   = 1'b0;
      win_valid = 1'b0;
      if (state_q == StLocked) begin
         win_src   = locked_src_q;
         win_valid = locked_src_q ? bus.data_req_i : bus.instr_req_i;
      end else begin
         win_valid = bus.instr_req_i | bus.data_req_i;
         if (bus.instr_req_i && bus.data_req_i) begin
            win_src = rr_q;
         end else begin
            win_src = bus.data_req_i;
         end
      end
   end

   // A response popping this cycle frees a slot, so a full FIFO can still accept.
   assign rsp      = bus.avm_readdatavalid_i | bus.avm_writeresponsevalid_i;
   assign rsp_ok   = rsp & (count_q != 3'd0) & ~rst_i;
   assign room     = (count_q != MaxCnt) | rsp_ok;
   assign cmd      = win_valid & room & ~rst_i;
   assign accept   = cmd & ~bus.avm_waitrequest_i;
   assign head_src = tag_q[rd_ptr_q];
   assign win_we   = win_src & bus.data_we_i;

   assign bus.avm_read_o       = cmd & ~win_we;
   assign bus.avm_write_o      = cmd & win_we;
   assign bus.avm_address_o    = cmd ? (win_src ? bus.data_addr_i : bus.instr_addr_i) : 32'h0;
   assign bus.avm_byteenable_o = win_src ? bus.data_be_i : 4'hF;
   assign bus.avm_writedata_o  = (cmd & win_src) ? bus.data_wdata_i : 32'h0;

   assign bus.instr_gnt_o = accept & ~win_src;
   assign bus.data_gnt_o  = accept & win_src;

   assign bus.instr_rvalid_o = rsp_ok & ~head_src;
   assign bus.data_rvalid_o  = rsp_ok & head_src;
   assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.avm_readdata_i : 32'h0;
   assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.avm_readdata_i : 32'h0;
   assign bus.instr_err_o    = bus.instr_rvalid_o & (bus.avm_response_i != 2'b00);
   assign bus.data_err_o     = bus.data_rvalid_o & (bus.avm_response_i != 2'b00);

   assign protocol_err_o = proto_err_q;

   // Arbitration FSM: lock onto a stalled command until it is accepted or withdrawn.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         locked_src_q <= 1'b0;
         rr_q         <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd && bus.avm_waitrequest_i) begin
                  state_q      <= StLocked;
                  locked_src_q <= win_src;
               end
            end
            StLocked: begin
               if (accept || !win_valid) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (accept) begin
            rr_q <= ~win_src;
         end
      end
   end

   // Tag FIFO, outstanding count and sticky protocol error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q     <= 3'd0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         tag_q       <= 4'h0;
         proto_err_q <= 1'b0;
      end else begin
         if (accept) begin
            tag_q[wr_ptr_q] <= win_src;
            wr_ptr_q        <= (wr_ptr_q == LastPtr) ? 2'd0 : wr_ptr_q + 2'd1;
         end
         if (rsp_ok) begin
            rd_ptr_q <= (rd_ptr_q == LastPtr) ? 2'd0 : rd_ptr_q + 2'd1;
         end
         if (accept && !rsp_ok) begin
            count_q <= count_q + 3'd1;
         end else if (!accept && rsp_ok) begin
            count_q <= count_q - 3'd1;
         end
         if (rsp && (count_q == 3'd0)) begin
            proto_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Directed bench for ibex_bus_arbiter with MAX_OUTST = 2.
module tb_ibex_bus_arbiter;

   logic clk_i = 1'b0;
   logic rst_i;
   logic protocol_err_o;

   int n_vec = 0;
   int n_err = 0;

   ibex_bus_arbiter_if bus ();

   ibex_bus_arbiter #(
      .MAX_OUTST (2)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .bus            (bus),
      .protocol_err_o (protocol_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      bus.instr_req_i              = 1'b0;
      bus.instr_addr_i             = 32'h0;
      bus.data_req_i               = 1'b0;
      bus.data_we_i                = 1'b0;
      bus.data_be_i                = 4'h0;
      bus.data_addr_i              = 32'h0;
      bus.data_wdata_i             = 32'h0;
      bus.avm_waitrequest_i        = 1'b0;
      bus.avm_readdatavalid_i      = 1'b0;
      bus.avm_writeresponsevalid_i = 1'b0;
      bus.avm_readdata_i           = 32'h0;
      bus.avm_response_i           = 2'b00;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic next();
      @(negedge clk_i);
      clr();
   endtask

   task automatic settle();
      #1;
   endtask

   // One I-only read accepted in the current cycle.
   task automatic ird(input logic [31:0] a);
      next();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = a;
      settle();
      check("ird_gnt", bus.instr_gnt_o, 1);
   endtask

   // One response; expects it routed to instr (src=0) or data (src=1).
   task automatic rsp(input logic src, input logic [31:0] d, input logic [1:0] r, input logic wr);
      next();
      bus.avm_readdatavalid_i      = ~wr;
      bus.avm_writeresponsevalid_i = wr;
      bus.avm_readdata_i           = d;
      bus.avm_response_i           = r;
      settle();
      check("rsp_irv", bus.instr_rvalid_o, {31'h0, ~src});
      check("rsp_drv", bus.data_rvalid_o, {31'h0, src});
      check("rsp_ird", bus.instr_rdata_o, src ? 32'h0 : d);
      check("rsp_drd", bus.data_rdata_o, src ? d : 32'h0);
      check("rsp_err", src ? bus.data_err_o : bus.instr_err_o, {31'h0, r != 2'b00});
   endtask

   initial begin
      clr();
      rst_i = 1'b1;
      @(negedge clk_i);
      next();
      // Reset holds everything low even with requests and responses present.
      bus.instr_req_i         = 1'b1;
      bus.instr_addr_i        = 32'hABCD;
      bus.avm_readdatavalid_i = 1'b1;
      settle();
      check("rst_gnt", bus.instr_gnt_o, 0);
      check("rst_read", bus.avm_read_o, 0);
      check("rst_addr", bus.avm_address_o, 0);
      check("rst_rvalid", bus.instr_rvalid_o, 0);
      check("rst_perr", protocol_err_o, 0);
      next();
      rst_i = 1'b0;
      settle();

      // Both request: I first, then D by round-robin.
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h1000;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 32'h2000;
      settle();
      check("rr0_ignt", bus.instr_gnt_o, 1);
      check("rr0_dgnt", bus.data_gnt_o, 0);
      check("rr0_addr", bus.avm_address_o, 32'h1000);
      check("rr0_read", bus.avm_read_o, 1);
      next();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h1004;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 32'h2000;
      settle();
      check("rr1_ignt", bus.instr_gnt_o, 0);
      check("rr1_dgnt", bus.data_gnt_o, 1);
      check("rr1_addr", bus.avm_address_o, 32'h2000);
      rsp(1'b0, 32'h0000_000A, 2'b00, 1'b0);
      rsp(1'b1, 32'h0000_000B, 2'b00, 1'b0);

      // Locked D write under waitrequest while I keeps requesting.
      ird(32'h1008);
      for (int c = 0; c < 4; c++) begin
         next();
         bus.instr_req_i       = 1'b1;
         bus.instr_addr_i      = 32'h3000;
         bus.data_req_i        = 1'b1;
         bus.data_we_i         = 1'b1;
         bus.data_be_i         = 4'h3;
         bus.data_addr_i       = 32'h100;
         bus.data_wdata_i      = 32'hDEADBEEF;
         bus.avm_waitrequest_i = (c < 3);
         settle();
         check("lk_write", bus.avm_write_o, 1);
         check("lk_read", bus.avm_read_o, 0);
         check("lk_addr", bus.avm_address_o, 32'h100);
         check("lk_be", {28'h0, bus.avm_byteenable_o}, 32'h3);
         check("lk_wdata", bus.avm_writedata_o, 32'hDEADBEEF);
         check("lk_ignt", bus.instr_gnt_o, 0);
         check("lk_dgnt", bus.data_gnt_o, {31'h0, c == 3});
      end
      rsp(1'b0, 32'h0000_0055, 2'b00, 1'b0);
      rsp(1'b1, 32'h0, 2'b00, 1'b1);

      // Locked requester withdraws: no grant that cycle, normal grant after.
      next();
      bus.data_req_i        = 1'b1;
      bus.data_addr_i       = 32'h200;
      bus.avm_waitrequest_i = 1'b1;
      settle();
      check("drop_dgnt0", bus.data_gnt_o, 0);
      next();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h4000;
      settle();
      check("drop_ignt", bus.instr_gnt_o, 0);
      check("drop_read", bus.avm_read_o, 0);
      ird(32'h4000);
      rsp(1'b0, 32'h0000_0066, 2'b00, 1'b0);

      // Full FIFO blocks; a response in the same cycle lets a third read through.
      ird(32'h5000);
      ird(32'h5004);
      next();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h5008;
      settle();
      check("full_read", bus.avm_read_o, 0);
      check("full_ignt", bus.instr_gnt_o, 0);
      next();
      bus.instr_req_i         = 1'b1;
      bus.instr_addr_i        = 32'h5008;
      bus.avm_readdatavalid_i = 1'b1;
      bus.avm_readdata_i      = 32'h12345678;
      settle();
      check("pp_irv", bus.instr_rvalid_o, 1);
      check("pp_ird", bus.instr_rdata_o, 32'h12345678);
      check("pp_read", bus.avm_read_o, 1);
      check("pp_ignt", bus.instr_gnt_o, 1);
      rsp(1'b0, 32'h0000_0077, 2'b00, 1'b0);
      rsp(1'b0, 32'h0000_0088, 2'b00, 1'b0);
      check("pp_perr", protocol_err_o, 0);

      // In-order routing with error response on the data side.
      ird(32'h6000);
      next();
      bus.data_req_i  = 1'b1;
      bus.data_addr_i = 32'h6100;
      settle();
      check("ord_dgnt", bus.data_gnt_o, 1);
      rsp(1'b0, 32'h0000_0011, 2'b00, 1'b0);
      rsp(1'b1, 32'h0000_0022, 2'b10, 1'b0);

      // Response with nothing outstanding.
      next();
      bus.avm_readdatavalid_i = 1'b1;
      bus.avm_readdata_i      = 32'h99;
      settle();
      check("orph_irv", bus.instr_rvalid_o, 0);
      check("orph_drv", bus.data_rvalid_o, 0);
      next();
      settle();
      check("orph_perr1", protocol_err_o, 1);
      next();
      settle();
      check("orph_perr2", protocol_err_o, 1);

      // Reset with two outstanding discards the tags.
      ird(32'h7000);
      ird(32'h7004);
      next();
      rst_i                   = 1'b1;
      bus.avm_readdatavalid_i = 1'b1;
      settle();
      check("mrst_irv", bus.instr_rvalid_o, 0);
      next();
      rst_i = 1'b0;
      settle();
      check("mrst_perr0", protocol_err_o, 0);
      bus.avm_readdatavalid_i = 1'b1;
      bus.avm_readdata_i      = 32'hAA;
      settle();
      check("mrst_irv2", bus.instr_rvalid_o, 0);
      check("mrst_drv2", bus.data_rvalid_o, 0);
      next();
      settle();
      check("mrst_perr1", protocol_err_o, 1);
      ird(32'h8000);
      rsp(1'b0, 32'h0000_00BB, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ibex_bus_arbiter.md
IBEX_BUS_ARBITER -- requirements
Module: ibex_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, range 1..4: maximum number of issued, unanswered Avalon commands.
REQ-002 SHALL have a single clock `clk_i` and a reset `rst_i`; reset is synchronous and active-high.
REQ-003 SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have the Ibex instruction-side ports:
- instr_req_i in 1, instr_addr_i in 32.
- instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1.
REQ-006 SHALL have the Ibex data-side ports:
- data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32.
- data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1.
REQ-007 SHALL have the Avalon-MM host ports:
- avm_address_o out 32, avm_read_o out 1, avm_write_o out 1, avm_byteenable_o out 4, avm_writedata_o out 32.
- avm_waitrequest_i in 1, avm_readdatavalid_i in 1, avm_writeresponsevalid_i in 1, avm_readdata_i in 32, avm_response_i in 2.
REQ-008 SHALL have port protocol_err_o  out  1  sticky flag: a response arrived with nothing outstanding.

Function
REQ-009 SHALL arbitrate two requesters (I = instr, D = data) onto one Avalon port with states IDLE and LOCKED.
REQ-010 In IDLE, winner selection SHALL be:
- only one request asserted: that requester wins;
- both asserted: the requester not granted most recently wins (1-bit round-robin pointer, reset value = I wins first).
REQ-011 Command drive SHALL be combinational from the winner:
- avm_read_o = winner valid & ~we; avm_write_o = winner valid & we;
- I is always a read with byteenable 4'hF and writedata 0;
- D passes data_we_i, data_be_i and data_wdata_i through.
REQ-012 No command SHALL be driven while outstanding count == MAX_OUTST; avm_read_o and avm_write_o are 0 in that case.
REQ-013 The winner's gnt SHALL be driven high in the same cycle that the command is driven and avm_waitrequest_i = 0.
- Acceptance adds zero cycles of latency.
- At most one gnt per cycle.
REQ-014 A command driven with avm_waitrequest_i = 1 SHALL move the arbiter to LOCKED.
- The selection is frozen; the other requester cannot win.
- Stays LOCKED until acceptance, then returns to IDLE.
REQ-015 If the locked requester deasserts req while LOCKED, the arbiter SHALL drop the command and return to IDLE next cycle with no grant.
REQ-016 On every accepted command the arbiter SHALL:
- push the source ID (0 = I, 1 = D) into an in-order tag FIFO of depth MAX_OUTST;
- set the round-robin pointer to favour the other requester.
REQ-017 A response (avm_readdatavalid_i | avm_writeresponsevalid_i) SHALL pop the FIFO head and assert the matching rvalid for exactly that cycle.
- rdata_o = avm_readdata_i.
- err_o = (avm_response_i != 2'b00).
REQ-018 rdata_o and err_o SHALL be forced to 0 whenever the corresponding rvalid is 0.
REQ-019 Acceptance and response in the same cycle SHALL push and pop together; the count is unchanged and this SHALL be legal even when count == MAX_OUTST.
REQ-020 A response when count == 0 SHALL be dropped: no rvalid is asserted and protocol_err_o is set.
REQ-021 The count SHALL never exceed MAX_OUTST and never wrap below 0; FIFO pointers wrap modulo MAX_OUTST.

Reset
REQ-022 While rst_i = 1, the following SHALL be cleared and gnt/rvalid held low:
- state → IDLE;
- count, FIFO pointers and round-robin pointer (I first) → 0;
- protocol_err_o → 0.
REQ-023 A reset asserted mid-transaction SHALL discard all outstanding tags; responses arriving after reset SHALL be treated per REQ-020.
REQ-024 While rst_i = 1, all outputs SHALL be 0 except avm_byteenable_o, which is don't-care with read/write low.

Verification
REQ-025 I and D both request a read in the same cycle with waitrequest = 0 -> cycle 0: instr_gnt_o = 1, avm_address_o = instr_addr_i. Cycle 1: data_gnt_o = 1.
REQ-026 D write (addr 0x100, be 4'h3, wdata 0xDEADBEEF) with waitrequest = 1 for 3 cycles while I requests -> avm command stable for 4 cycles; data_gnt_o in cycle 3; no instr_gnt_o during cycles 0-3.
REQ-027 MAX_OUTST = 2; two I reads accepted, no responses yet -> avm_read_o = 0 and instr_gnt_o = 0. readdatavalid with 0x12345678 -> instr_rvalid_o = 1, instr_rdata_o = 0x12345678; a third read is accepted in the same cycle.
REQ-028 I read then D read outstanding; responses with response = 2'b00 then 2'b10 -> instr_rvalid_o (err 0) first, then data_rvalid_o with data_err_o = 1.
REQ-029 avm_readdatavalid_i pulsed with count = 0 -> no rvalid; protocol_err_o = 1 until rst_i.
REQ-030 rst_i pulsed with 2 outstanding, then one response arrives -> no rvalid, protocol_err_o = 1, and the next request is granted normally.
